// File: rtl/tpuv2_ctrl.sv
// Host-bus front end and matmul sequencer for the second-generation TPU.
// Decodes host beats into memA/memB/systolic_array control and runs the CLR/RUN/DONE sequence.
module tpuv2_ctrl #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 64,
  localparam int RW     = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    r_w,
  input  logic [ADDRW-1:0]        addr,
  input  logic [DATAW-1:0]        dataIn,
  output logic [DATAW-1:0]        dataOut,
  output logic                    rd_valid,
  output logic                    memA_en,
  output logic                    memA_WrEn,
  output logic [RW-1:0]           Arow,
  output logic                    memB_en,
  output logic [DIM*BITS_AB-1:0]  ab_data,
  output logic                    zero_pad_AB,
  output logic                    sys_en,
  output logic                    sys_WrEn,
  output logic                    sys_clr,
  output logic [RW-1:0]           Crow,
  output logic [DIM*BITS_C-1:0]   Cin,
  input  logic [DIM*BITS_C-1:0]   Cout,
  output logic                    busy,
  output logic                    done_irq,
  output logic [1:0]              state_dbg
);

  localparam int CBEATS = DIM * BITS_C / DATAW;
  localparam int STRIDE = DATAW / 8;
  localparam int MC     = 3 * DIM - 2;
  localparam int TW     = (MC > 1) ? $clog2(MC) : 1;
  localparam int KW     = (CBEATS > 1) ? $clog2(CBEATS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLR  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [TW-1:0]    timer;
  logic             done_q;
  logic             err_q;
  logic [DATAW-1:0] stage_q [CBEATS];

  logic [7:0]       ofs;
  logic [7:0]       idx;
  logic [ADDRW-9:0] page;
  logic             aligned;
  logic             hit_a, hit_b, hit_c, hit_ctrl, hit_stat;
  logic             go, allow, err_set;
  logic             wr_a, wr_b, wr_c, rd_c, wr_ctrl, wr_stat, start;
  logic [RW-1:0]    c_row;
  logic [KW-1:0]    c_k;
  logic             c_last;
  logic [DATAW-1:0] rdata;

  // Host handshake: a beat is accepted whenever req=1 (no backpressure); a read beat
  // always returns exactly one rd_valid pulse on the following cycle with dataOut.
  assign ofs     = addr[7:0];
  assign page    = addr[ADDRW-1:8];
  assign aligned = (addr & ADDRW'(STRIDE - 1)) == '0;
  assign idx     = ofs >> $clog2(STRIDE);
  assign c_row   = RW'(idx / CBEATS);
  assign c_k     = KW'(idx % CBEATS);
  assign c_last  = c_k == KW'(CBEATS - 1);

  assign hit_a    = aligned && page == (ADDRW-8)'(1) && idx < 8'(DIM);
  assign hit_b    = aligned && page == (ADDRW-8)'(2) && idx < 8'(DIM);
  assign hit_c    = aligned && page == (ADDRW-8)'(3) && idx < 8'(DIM * CBEATS);
  assign hit_ctrl = addr == ADDRW'(16'h0400);
  assign hit_stat = addr == ADDRW'(16'h0408);

  assign busy    = state != S_IDLE;
  assign go      = req && !rst;
  assign allow   = go && !busy;
  // Array-side accesses collide with a running matmul; only STATUS stays reachable.
  assign err_set = go && busy && (hit_a || hit_b || hit_c || hit_ctrl);

  assign wr_a    = allow && r_w && hit_a;
  assign wr_b    = allow && r_w && hit_b;
  assign wr_c    = allow && r_w && hit_c;
  assign rd_c    = allow && !r_w && hit_c;
  assign wr_ctrl = allow && r_w && hit_ctrl;
  assign wr_stat = go && r_w && hit_stat;
  assign start   = wr_ctrl && dataIn[0];

  assign sys_clr     = state == S_CLR;
  assign sys_en      = state == S_RUN;
  assign memA_en     = sys_en;
  assign zero_pad_AB = sys_en;
  assign memB_en     = sys_en || wr_b;
  assign memA_WrEn   = wr_a;
  assign Arow        = wr_a ? RW'(idx) : '0;
  assign ab_data     = (wr_a || wr_b) ? dataIn[DIM*BITS_AB-1:0] : '0;
  assign sys_WrEn    = wr_c && c_last;
  assign Crow        = (wr_c || rd_c) ? c_row : '0;
  assign done_irq    = state == S_DONE;
  assign state_dbg   = state;

  always_comb begin
    Cin = '0;
    if (sys_WrEn) begin
      for (int k = 0; k < CBEATS; k++) begin
        Cin[k*DATAW +: DATAW] = (k == CBEATS - 1) ? dataIn : stage_q[k];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (go && hit_stat) rdata = DATAW'({err_q, done_q, busy});
    else if (rd_c)      rdata = Cout[c_k*DATAW +: DATAW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= dataIn[1] ? S_RUN : S_CLR;
        S_CLR:   state <= S_RUN;
        S_RUN:   if (timer == TW'(MC - 1)) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer <= '0;
    else     timer <= (state == S_RUN) ? timer + TW'(1) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dataOut  <= '0;
      rd_valid <= 1'b0;
      for (int k = 0; k < CBEATS; k++) stage_q[k] <= '0;
    end else begin
      // Setting the sticky done flag takes priority over a same-cycle clear.
      if (state == S_DONE)             done_q <= 1'b1;
      else if (wr_stat && dataIn[1])   done_q <= 1'b0;
      if (err_set)                     err_q  <= 1'b1;
      else if (wr_stat && dataIn[2])   err_q  <= 1'b0;
      if (wr_c && !c_last)             stage_q[c_k] <= dataIn;
      rd_valid <= go && !r_w;
      dataOut  <= rdata;
    end
  end

endmodule
